// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and data-memory freezes.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_control_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned BRANCH_PENALTY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instruction,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_branch_taken,
    input  logic        mem_access,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_flush,
    output logic        pipe_freeze,
    output logic [1:0]  state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned REG_W = 5;

    localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_S     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_SB    = 7'b1100011;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rs1, rs2;
    logic               rs1_used, rs2_used, hazard, freeze, stall_cycle;
    logic               unused_instr_bits;

    assign opcode = id_instruction[6:0];
    assign rs1    = id_instruction[19:15];
    assign rs2    = id_instruction[24:20];
    assign unused_instr_bits = ^{id_instruction[31:25], id_instruction[14:7]};

    // Operand-use decode and load-use detection; x0 is never a real dependency
    assign rs1_used = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
    assign rs2_used = (opcode == OPC_R) || (opcode == OPC_S) || (opcode == OPC_SB);
    assign hazard   = ex_mem_read && (ex_rd != '0) &&
                      ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    assign freeze   = mem_access && !mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and control outputs; priority reset > freeze > branch > load-use
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        stall_cycle  = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = RUN;
            cnt_d        = '0;
        end else if (freeze) begin
            pipe_freeze  = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
        end else begin
            unique case (state_q)
                RUN, LOAD_STALL: begin
                    stall_cycle = (state_q == LOAD_STALL) || (hazard && !mem_branch_taken);
                    if (mem_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        ex_mem_flush = 1'b1;
                        if (BRANCH_PENALTY > 0) begin
                            state_d = BR_FLUSH;
                            cnt_d   = CNT_W'(BRANCH_PENALTY);
                        end else begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end
                    end else if (state_q == LOAD_STALL || hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (state_q == LOAD_STALL) begin
                            cnt_d = cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) state_d = RUN;
                        end else if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                BR_FLUSH: begin
                    if_id_flush = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_EN
    // Saturating event counters; frozen cycles and reset cycles never count
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (!freeze) begin
            if (stall_cycle && (stall_count != '1)) stall_count <= stall_count + 32'd1;
            if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + 32'd1;
        end
    end
`else
    logic unused_stall_cycle;
    assign unused_stall_cycle = stall_cycle;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances with different stall/penalty settings.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id;
    logic        emr, mbt, ma, mr;
    logic [4:0]  rd;

    wire  [1:0]  st_a, st_b, st_c;
    wire  [5:0]  ctl_a, ctl_b, ctl_c;
`ifdef HAZARD_PERF_EN
    wire  [31:0] sc_a, fc_a, sc_b, fc_b, sc_c, fc_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .BRANCH_PENALTY(1)) dut_a (
        .clk(clk), .reset(reset), .id_instruction(id), .ex_mem_read(emr), .ex_rd(rd),
        .mem_branch_taken(mbt), .mem_access(ma), .mem_ready(mr),
        .pc_write(ctl_a[5]), .if_id_write(ctl_a[4]), .if_id_flush(ctl_a[3]),
        .id_ex_bubble(ctl_a[2]), .ex_mem_flush(ctl_a[1]), .pipe_freeze(ctl_a[0]), .state(st_a)
`ifdef HAZARD_PERF_EN
        , .stall_count(sc_a), .flush_count(fc_a)
`endif
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(2), .BRANCH_PENALTY(1)) dut_b (
        .clk(clk), .reset(reset), .id_instruction(id), .ex_mem_read(emr), .ex_rd(rd),
        .mem_branch_taken(mbt), .mem_access(ma), .mem_ready(mr),
        .pc_write(ctl_b[5]), .if_id_write(ctl_b[4]), .if_id_flush(ctl_b[3]),
        .id_ex_bubble(ctl_b[2]), .ex_mem_flush(ctl_b[1]), .pipe_freeze(ctl_b[0]), .state(st_b)
`ifdef HAZARD_PERF_EN
        , .stall_count(sc_b), .flush_count(fc_b)
`endif
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(0)) dut_c (
        .clk(clk), .reset(reset), .id_instruction(id), .ex_mem_read(emr), .ex_rd(rd),
        .mem_branch_taken(mbt), .mem_access(ma), .mem_ready(mr),
        .pc_write(ctl_c[5]), .if_id_write(ctl_c[4]), .if_id_flush(ctl_c[3]),
        .id_ex_bubble(ctl_c[2]), .ex_mem_flush(ctl_c[1]), .pipe_freeze(ctl_c[0]), .state(st_c)
`ifdef HAZARD_PERF_EN
        , .stall_count(sc_c), .flush_count(fc_c)
`endif
    );

    // Expected vector {state, pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze}
    function automatic logic [7:0] v(input logic [1:0] s, input logic [5:0] c);
        return {s, c};
    endfunction
    function automatic logic [7:0] nrm(input logic [1:0] s); return v(s, 6'b110000); endfunction
    function automatic logic [7:0] stl(input logic [1:0] s); return v(s, 6'b000100); endfunction
    function automatic logic [7:0] brn(input logic [1:0] s); return v(s, 6'b111110); endfunction
    function automatic logic [7:0] brf(input logic [1:0] s); return v(s, 6'b111000); endfunction
    function automatic logic [7:0] frz(input logic [1:0] s); return v(s, 6'b000001); endfunction
    function automatic logic [7:0] rst(input logic [1:0] s); return v(s, 6'b001110); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] ec);
        chk({tag, "/a"}, 32'({st_a, ctl_a}), 32'(ea));
        chk({tag, "/b"}, 32'({st_b, ctl_b}), 32'(eb));
        chk({tag, "/c"}, 32'({st_c, ctl_c}), 32'(ec));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; id = 32'h0000_0013; emr = 1'b0; rd = 5'd0;
        mbt = 1'b0; ma = 1'b0; mr = 1'b1;

        // Reset held two cycles, then idle release
        tick; tick;
        chk3("reset", rst(0), rst(0), rst(0));
`ifdef HAZARD_PERF_EN
        chk("rst_stall_count", sc_b, 32'd0);
        chk("rst_flush_count", fc_b, 32'd0);
`endif
        reset = 1'b0; #1;
        chk3("idle", nrm(0), nrm(0), nrm(0));

        // Load-use on add x6,x5,x7 with load to x5
        id = 32'h0072_8333; emr = 1'b1; rd = 5'd5; #1;
        chk3("lu_detect", stl(0), stl(0), stl(0));
        tick; emr = 1'b0; #1;
        chk3("lu_cyc2", nrm(0), stl(1), stl(1));
        tick;
        chk3("lu_cyc3", nrm(0), nrm(0), stl(1));
        tick;
        chk3("lu_done", nrm(0), nrm(0), nrm(0));

        // Operand-use filtering
        emr = 1'b1; rd = 5'd5; id = 32'h0050_8313; #1;
        chk3("addi_rs2field", nrm(0), nrm(0), nrm(0));
        id = 32'h0000_02B7; #1;
        chk3("lui_rd5", nrm(0), nrm(0), nrm(0));
        id = 32'h0002_8337; #1;
        chk3("lui_rs1field", nrm(0), nrm(0), nrm(0));
        rd = 5'd0; id = 32'h0000_0033; #1;
        chk3("x0_dest", nrm(0), nrm(0), nrm(0));
        rd = 5'd5; id = 32'h0012_8313; #1;
        chk3("addi_rs1", stl(0), stl(0), stl(0));
        id = 32'h0051_2023; #1;
        chk3("sw_rs2", stl(0), stl(0), stl(0));
        emr = 1'b0;
        tick; tick; tick;
        chk3("sw_recover", nrm(0), nrm(0), nrm(0));

        // Taken branch pulse
        mbt = 1'b1; #1;
        chk3("br_cycle", brn(0), brn(0), brn(0));
        tick; mbt = 1'b0; #1;
        chk3("br_flush", brf(2), brf(2), nrm(0));
        tick;
        chk3("br_done", nrm(0), nrm(0), nrm(0));

        // Memory freeze over a pending load-use hazard
        id = 32'h0072_8333; emr = 1'b1; rd = 5'd5; ma = 1'b1; mr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk3("frz_run", frz(0), frz(0), frz(0));
            tick;
        end
        mr = 1'b1; #1;
        chk3("frz_release", stl(0), stl(0), stl(0));
        tick; emr = 1'b0; mr = 1'b0; #1;
        chk3("frz_in_stall", frz(0), frz(1), frz(1));
        tick;
        chk3("frz_hold", frz(0), frz(1), frz(1));
        mr = 1'b1; #1;
        chk3("frz_resume", nrm(0), stl(1), stl(1));
        tick; ma = 1'b0; #1;
        chk3("frz_cnt", nrm(0), nrm(0), stl(1));
        tick;
        chk3("frz_done", nrm(0), nrm(0), nrm(0));

        // Branch aborting a multi-cycle load stall
        reset = 1'b1; tick; reset = 1'b0;
        id = 32'h0072_8333; emr = 1'b1; rd = 5'd5; #1;
        chk3("abort_hazard", stl(0), stl(0), stl(0));
        tick; emr = 1'b0; mbt = 1'b1; #1;
        chk3("abort_branch", brn(0), brn(1), brn(1));
        tick; mbt = 1'b0; #1;
        chk3("abort_flush", brf(2), brf(2), nrm(0));
        tick;
        chk3("abort_done", nrm(0), nrm(0), nrm(0));
`ifdef HAZARD_PERF_EN
        chk("perf_stall_count", sc_b, 32'd2);
        chk("perf_flush_count", fc_b, 32'd2);
`endif

        // Freeze masks a taken branch
        ma = 1'b1; mr = 1'b0; mbt = 1'b1; #1;
        chk3("frz_branch", frz(0), frz(0), frz(0));
        tick; ma = 1'b0; mbt = 1'b0; #1;
        chk3("frz_branch_after", nrm(0), nrm(0), nrm(0));
`ifdef HAZARD_PERF_EN
        chk("perf_hold_stall", sc_b, 32'd2);
        chk("perf_hold_flush", fc_b, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
